twiddle_addr_gen: RTL and testbench

- Parametrised quarter-wave twiddle address generator for the FFT datapath.
- Produces cos and sin ROM addresses from one shared quarter-wave table T[i] = cos(2*pi*i/2^MAX_LOG2_N), i = 0..2^(MAX_LOG2_N-2)-1.
- Drives folding flags (negate / force-zero) aligned to the external ROM read latency.
- Adds over the previous generation: runtime transform length, runtime twiddle stride, frame restart, and exact handling of the pi/2 points that fall outside the table.

---
 rtl/twiddle_addr_gen.sv | 160 ++++++++++++++++
 tb/tb_twiddle_addr_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_addr_gen.sv
// Quarter-wave twiddle address generator: phase accumulator folded onto one
// cos table, with negate/zero flags delayed to line up with ROM read data.
module twiddle_addr_gen #(
    parameter int unsigned MAX_LOG2_N  = 15,
    parameter int unsigned LOG2N_W     = 4,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned ADDR_W      = MAX_LOG2_N - 2
) (
    input  logic                  clk_fft,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  en,
    input  logic [LOG2N_W-1:0]    log2_n,
    input  logic [MAX_LOG2_N-1:0] step,
    output logic [ADDR_W-1:0]     rom_add_cos,
    output logic [ADDR_W-1:0]     rom_add_sin,
    output logic                  addr_valid,
    output logic [MAX_LOG2_N-1:0] count,
    output logic                  busy,
    output logic                  tw_valid,
    output logic                  tw_last,
    output logic                  cos_neg,
    output logic                  cos_zero,
    output logic                  sin_neg,
    output logic                  sin_zero
);

    localparam int unsigned LW = $clog2(MAX_LOG2_N + 1);
    localparam int unsigned PW = ROM_LATENCY * 6;
    localparam logic [MAX_LOG2_N-1:0] ONE_N = 1;
    localparam logic [MAX_LOG2_N-1:0] ALL1  = '1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [LW-1:0]         len_q;
    logic [MAX_LOG2_N-1:0] step_q;
    logic [MAX_LOG2_N-1:0] phase;
    logic [MAX_LOG2_N-1:0] n_q;

    logic                  restart, accept, frame_end;
    logic [LW-1:0]         len_in, len_sel, shamt;
    logic [MAX_LOG2_N-1:0] step_sel, inc, p_cur, n_cur, n_last;
    logic [1:0]            quad;
    logic [ADDR_W-1:0]     r, r_c;
    logic                  r_zero;
    logic [ADDR_W-1:0]     cos_a, sin_a;
    logic                  c_neg, c_zero, s_neg, s_zero;

    logic                  last1, cn1, cz1, sn1, sz1;
    logic [PW-1:0]         pipe;

    always_comb begin
        if (32'(log2_n) < 32'd4)
            len_in = LW'(4);
        else if (32'(log2_n) > MAX_LOG2_N)
            len_in = LW'(MAX_LOG2_N);
        else
            len_in = LW'(log2_n);
    end

    assign restart  = en & start;
    assign accept   = en & (start | (state == ST_RUN));
    assign len_sel  = restart ? len_in : len_q;
    assign step_sel = restart ? step : step_q;
    assign shamt    = LW'(MAX_LOG2_N) - len_sel;
    assign inc      = step_sel << shamt;
    assign p_cur    = restart ? '0 : phase;
    assign n_cur    = restart ? '0 : n_q;
    assign n_last   = ~(ALL1 << len_sel);
    assign frame_end = (n_cur == n_last);

    assign quad   = p_cur[MAX_LOG2_N-1 -: 2];
    assign r      = p_cur[ADDR_W-1:0];
    assign r_c    = '0 - r;
    assign r_zero = (r == '0);

    // Q-r wraps to address 0 when r=0; that point is the exact zero, so the
    // zero flag is raised and the negate flag suppressed.
    always_comb begin
        cos_a  = r;
        sin_a  = r_c;
        c_neg  = 1'b0;
        c_zero = 1'b0;
        s_neg  = 1'b0;
        s_zero = r_zero;
        case (quad)
            2'd1: begin
                cos_a  = r_c;  c_neg = ~r_zero; c_zero = r_zero;
                sin_a  = r;    s_neg = 1'b0;    s_zero = 1'b0;
            end
            2'd2: begin
                cos_a  = r;    c_neg = 1'b1;    c_zero = 1'b0;
                sin_a  = r_c;  s_neg = ~r_zero; s_zero = r_zero;
            end
            2'd3: begin
                cos_a  = r_c;  c_neg = 1'b0;    c_zero = r_zero;
                sin_a  = r;    s_neg = 1'b1;    s_zero = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_fft or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            step_q <= '0;
            phase  <= '0;
            n_q    <= '0;
        end else if (accept) begin
            state <= frame_end ? ST_IDLE : ST_RUN;
            phase <= p_cur + inc;
            n_q   <= n_cur + ONE_N;
            if (restart) begin
                len_q  <= len_in;
                step_q <= step;
            end
        end
    end

    always_ff @(posedge clk_fft or negedge reset_n) begin
        if (!reset_n) begin
            addr_valid  <= 1'b0;
            rom_add_cos <= '0;
            rom_add_sin <= '0;
            count       <= '0;
            last1       <= 1'b0;
            cn1         <= 1'b0;
            cz1         <= 1'b0;
            sn1         <= 1'b0;
            sz1         <= 1'b0;
        end else begin
            addr_valid <= accept;
            last1      <= accept & frame_end;
            if (accept) begin
                rom_add_cos <= cos_a;
                rom_add_sin <= sin_a;
                count       <= n_cur;
                cn1         <= c_neg;
                cz1         <= c_zero;
                sn1         <= s_neg;
                sz1         <= s_zero;
            end
        end
    end

    // Free-running shift so flags track ROM data even while en is low.
    always_ff @(posedge clk_fft or negedge reset_n) begin
        if (!reset_n)
            pipe <= '0;
        else
            pipe <= PW'({pipe, addr_valid, last1, cn1, cz1, sn1, sz1});
    end

    assign {tw_valid, tw_last, cos_neg, cos_zero, sin_neg, sin_zero} = pipe[PW-1 -: 6];
    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Randomised bench for twiddle_addr_gen against a phase = n*stride model.
module tb_twiddle_addr_gen;

    localparam int unsigned MAXL = 15;
    localparam int unsigned RL   = 2;
    localparam int unsigned QW   = 8192;

    logic        clk_fft = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        en      = 1'b0;
    logic [3:0]  log2_n  = '0;
    logic [14:0] step    = '0;
    logic [12:0] rom_add_cos, rom_add_sin;
    logic        addr_valid, busy, tw_valid, tw_last;
    logic [14:0] count;
    logic        cos_neg, cos_zero, sin_neg, sin_zero;

    twiddle_addr_gen #(.MAX_LOG2_N(15), .LOG2N_W(4), .ROM_LATENCY(RL)) dut (
        .clk_fft(clk_fft), .reset_n(reset_n), .start(start), .en(en),
        .log2_n(log2_n), .step(step),
        .rom_add_cos(rom_add_cos), .rom_add_sin(rom_add_sin),
        .addr_valid(addr_valid), .count(count), .busy(busy),
        .tw_valid(tw_valid), .tw_last(tw_last),
        .cos_neg(cos_neg), .cos_zero(cos_zero),
        .sin_neg(sin_neg), .sin_zero(sin_zero)
    );

    always #5 clk_fft = ~clk_fft;

    typedef struct {
        int unsigned due;
        logic cn, cz, sn, sz, last;
    } tw_t;
    tw_t twq[$];

    int unsigned total = 0, bad = 0;
    int unsigned cyc = 0, pulses = 0, lasts = 0;
    bit          m_run = 0;
    int unsigned m_n = 0, m_L = 4, m_step = 0;
    int unsigned e_cos = 0, e_sin = 0, e_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // cos/sin of a phase by quadrant: index r or Q-r, sign from quadrant,
    // Q-r with r=0 lands on the exact-zero point outside the table.
    function automatic void fold(input int unsigned p,
                                 output int unsigned ac, output int unsigned as,
                                 output logic cn, output logic cz,
                                 output logic sn, output logic sz);
        int unsigned q = p / QW;
        int unsigned r = p % QW;
        bit c_comp = (q == 1) || (q == 3);
        cn = (q == 1) || (q == 2);
        sn = (q >= 2);
        cz = 0; sz = 0;
        if (c_comp && r == 0) begin ac = 0; cz = 1; cn = 0; end
        else ac = c_comp ? QW - r : r;
        if (!c_comp && r == 0) begin as = 0; sz = 1; sn = 0; end
        else as = c_comp ? r : QW - r;
    endfunction

    task automatic tick(input logic e, input logic s, input logic [3:0] ln, input logic [14:0] st);
        bit acc;
        @(negedge clk_fft);
        en = e; start = s; log2_n = ln; step = st;
        acc = e && (m_run || s);
        if (acc) begin
            int unsigned incr, p;
            bit lastf;
            tw_t t;
            if (s) begin
                m_n = 0;
                m_L = (int'(ln) < 4) ? 4 : ((int'(ln) > MAXL) ? MAXL : int'(ln));
                m_step = st;
            end
            incr = m_step << (MAXL - m_L);
            p = int'((longint'(m_n) * longint'(incr)) % 32768);
            fold(p, e_cos, e_sin, t.cn, t.cz, t.sn, t.sz);
            lastf = (m_n == (1 << m_L) - 1);
            e_cnt = m_n;
            t.last = lastf;
            t.due = cyc + 1 + RL;
            twq.push_back(t);
            m_n++;
            m_run = !lastf;
        end
        @(posedge clk_fft); #1;
        cyc++;
        if (addr_valid === 1'b1) pulses++;
        if (tw_valid === 1'b1 && tw_last === 1'b1) lasts++;
        chk("addr_valid", 32'(addr_valid), 32'(acc));
        chk("cos_addr", 32'(rom_add_cos), e_cos);
        chk("sin_addr", 32'(rom_add_sin), e_sin);
        chk("count", 32'(count), e_cnt);
        chk("busy", 32'(busy), 32'(m_run));
        if (twq.size() > 0 && twq[0].due == cyc) begin
            chk("tw_valid", 32'(tw_valid), 1);
            chk("tw_last", 32'(tw_last), 32'(twq[0].last));
            chk("cos_neg", 32'(cos_neg), 32'(twq[0].cn));
            chk("cos_zero", 32'(cos_zero), 32'(twq[0].cz));
            chk("sin_neg", 32'(sin_neg), 32'(twq[0].sn));
            chk("sin_zero", 32'(sin_zero), 32'(twq[0].sz));
            void'(twq.pop_front());
        end else begin
            chk("tw_idle", 32'(tw_valid), 0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < int'(RL) + 2; i++) tick(0, 0, 4'd4, 15'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_fft);
        reset_n = 0; en = 0; start = 0;
        #1;
        chk("rst_cos", 32'(rom_add_cos), 0);
        chk("rst_sin", 32'(rom_add_sin), 0);
        chk("rst_av", 32'(addr_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_twv", 32'(tw_valid), 0);
        chk("rst_twl", 32'(tw_last), 0);
        chk("rst_flags", 32'({cos_neg, cos_zero, sin_neg, sin_zero}), 0);
        m_run = 0; m_n = 0; e_cos = 0; e_sin = 0; e_cnt = 0;
        twq.delete();
        @(posedge clk_fft); #1;
        chk("rst_busy_hold", 32'(busy), 0);
        @(negedge clk_fft);
        reset_n = 1;
    endtask

    initial begin
        do_reset();

        // default frame, en held high
        for (int i = 0; i < 16; i++) begin
            tick(1, (i == 0), 4'd4, 15'd1);
            if (i == 1) begin
                chk("d_n1_cos", 32'(rom_add_cos), 2048);
                chk("d_n1_sin", 32'(rom_add_sin), 6144);
            end
            if (i == 4) chk("d_n4_sin", 32'(rom_add_sin), 0);
            if (i == 10) begin
                chk("d_n10_cos", 32'(rom_add_cos), 4096);
                chk("d_n10_sin", 32'(rom_add_sin), 4096);
            end
        end
        drain();

        // en toggling across one frame
        pulses = 0;
        tick(1, 1, 4'd4, 15'd1);
        for (int k = 1; k < 64 && m_run; k++) tick((k % 2) == 0, 0, 4'd4, 15'd1);
        drain();
        chk("toggle_pulses", pulses, 16);

        // clamped short frame, then the full-length frame
        pulses = 0;
        tick(1, 1, 4'd2, 15'd1);
        for (int k = 1; k < 64 && m_run; k++) tick(1, 0, 4'd2, 15'd1);
        drain();
        chk("clamp_pulses", pulses, 16);

        pulses = 0;
        for (int i = 0; i < 32768; i++) begin
            tick(1, (i == 0), 4'd15, 15'd3);
            if (i == 2731) begin
                chk("d_2731_cnt", 32'(count), 2731);
                chk("d_2731_cos", 32'(rom_add_cos), 8191);
                chk("d_2731_sin", 32'(rom_add_sin), 1);
            end
        end
        drain();
        chk("long_pulses", pulses, 32768);

        // restart at n=7 of a running frame
        lasts = 0;
        for (int i = 0; i < 8; i++) tick(1, (i == 0) || (i == 7), 4'd4, (i == 7) ? 15'd5 : 15'd1);
        for (int k = 0; k < 64 && m_run; k++) tick(1, 0, 4'd4, 15'd1);
        drain();
        chk("abort_lasts", lasts, 1);

        // step 0 and back-to-back frames
        pulses = 0;
        for (int i = 0; i < 64; i++) tick(1, (i == 0) || (i == 32), 4'd5, 15'd0);
        drain();
        chk("b2b_pulses", pulses, 64);

        // reset in the middle of a frame
        for (int i = 0; i < 6; i++) tick(1, (i == 0), 4'd4, 15'd1);
        do_reset();
        for (int i = 0; i < 6; i++) tick(1, 0, 4'd4, 15'd1);
        for (int i = 0; i < 16; i++) tick(1, (i == 0), 4'd4, 15'd7);
        drain();

        // random frames with random en and occasional restarts
        for (int f = 0; f < 6; f++) begin
            tick(1, 1, 4'($urandom_range(0, 9)), 15'($urandom));
            for (int k = 0; k < 4000 && m_run; k++) begin
                if ($urandom_range(0, 99) == 0)
                    tick(1'($urandom_range(0, 1)), 1, 4'($urandom_range(0, 9)), 15'($urandom));
                else
                    tick($urandom_range(0, 3) != 0, 0, 4'($urandom_range(0, 15)), 15'($urandom));
            end
            drain();
            chk("rand_end_busy", 32'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
